mp_coeff_loader: RTL
====================

MP_COEFF_LOADER -- requirements
Module: mp_coeff_loader

Interface
REQ-001 SHALL have parameter M, default 3, giving the memory depth; there SHALL be M+1 LUTs, numbered 0..M.
REQ-002 SHALL have parameter RESOLUTION, default 4096, giving the number of words per LUT.
REQ-003 SHALL have parameter COEFF_WIDTH, default $clog2(RESOLUTION), giving the LUT address width.
REQ-004 SHALL have port AXI_clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_ni, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port start_i, input, 1 bit: single-cycle load request.
REQ-007 SHALL have port all_i, input, 1 bit, sampled with start_i: 1 = load LUT 0..M back-to-back.
REQ-008 SHALL have port lut_sel_i, input, $clog2(M)+1 bits: target LUT when all_i=0.
REQ-009 SHALL have port abort_i, input, 1 bit: cancels an active load.
REQ-010 SHALL have port s_tdata, input, 32 bits: coefficient word, I in [31:16] and Q in [15:0].
REQ-011 SHALL have port s_tvalid, input, 1 bit; s_tready, output, 1 bit; s_tlast, input, 1 bit (marks the last word of one LUT).
REQ-012 SHALL have port coeff_data_o, output, 32 bits: LUT write data.
REQ-013 SHALL have port coeff_addr_o, output, COEFF_WIDTH bits: LUT write address.
REQ-014 SHALL have port coeff_num_o, output, $clog2(M)+1 bits: LUT write select.
REQ-015 SHALL have port coeff_en_o, output, 1 bit: LUT write strobe.
REQ-016 SHALL have port busy_o, output, 1 bit; done_o, output, 1 bit, one-cycle pulse; err_o, output, 1 bit, sticky.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD and DONE.
REQ-018 In IDLE, s_tready SHALL be 0; in LOAD, s_tready SHALL be 1; in DONE, s_tready SHALL be 0.
REQ-019 In IDLE on start_i=1: if all_i=1, SHALL set num=0, addr=0 and go to LOAD.
REQ-020 In IDLE on start_i=1 with all_i=0: if lut_sel_i<=M, SHALL set num=lut_sel_i, addr=0 and go to LOAD; otherwise SHALL set err_o=1 and stay in IDLE.
REQ-021 An accepted start (one that enters LOAD) SHALL clear err_o in the same edge.
REQ-022 start_i SHALL be ignored outside IDLE.
REQ-023 A handshake (s_tvalid & s_tready) at edge n SHALL drive coeff_en_o=1 during cycle n+1, with coeff_data_o=s_tdata, coeff_addr_o=addr and coeff_num_o=num as captured at edge n (registered, one-cycle latency).
REQ-024 coeff_en_o SHALL be 0 in every cycle not following a handshake; coeff_data_o, coeff_addr_o and coeff_num_o SHALL hold their last values.
REQ-025 On each handshake with addr<RESOLUTION-1 and s_tlast=0, SHALL increment addr by 1.
REQ-026 On a handshake with addr<RESOLUTION-1 and s_tlast=1 (early last), the word SHALL be written, err_o SHALL be set to 1, and the FSM SHALL go to IDLE with no done_o.
REQ-027 On a handshake with addr=RESOLUTION-1 and s_tlast=0 (missing last), the word SHALL be written and err_o SHALL be set to 1; the table SHALL then be treated as complete (REQ-028 applies).
REQ-028 On a handshake with addr=RESOLUTION-1: if all mode and num<M, SHALL set num=num+1, addr=0 and stay in LOAD; otherwise SHALL go to DONE.
REQ-029 The address SHALL never wrap past RESOLUTION-1 within one LUT.
REQ-030 DONE SHALL last exactly one cycle with done_o=1, then go to IDLE.
REQ-031 busy_o SHALL be 1 exactly when the state is LOAD.
REQ-032 abort_i=1 in LOAD SHALL go to IDLE and block that cycle's handshake (s_tready=0 while abort_i=1); a write strobe from the previous cycle's handshake SHALL still complete; no done_o.
REQ-033 abort_i outside LOAD SHALL have no effect.
REQ-034 With s_tvalid=0 in LOAD, state and addr SHALL hold (arbitrary stalls allowed).

Reset
REQ-035 While reset_ni=0: state=IDLE, addr=0, num=0, coeff_en_o=0, coeff_data_o=0, coeff_addr_o=0, coeff_num_o=0, s_tready=0, busy_o=0, done_o=0, err_o=0, applied asynchronously.
REQ-036 Reset asserted mid-LOAD SHALL discard the load: no further coeff_en_o and no done_o; the next load SHALL restart at addr 0.

Verification (RESOLUTION=16, M=3)
REQ-037 start_i, all_i=0, lut_sel_i=2, 16 words 0x00010000+k with tlast on k=15 -> coeff_en_o high 16 cycles, addr 0..15, num=2, data matches, done_o pulse, err_o=0.
REQ-038 start_i, all_i=1, 64 words with tlast every 16th -> num steps 0,1,2,3, addr restarts at 0 per LUT, exactly one done_o after the 64th write.
REQ-039 Single LUT load with s_tlast=1 on word 5 -> six writes (addr 0..5), err_o=1, back to IDLE, no done_o; a following valid start clears err_o.
REQ-040 start_i with lut_sel_i=4 -> err_o=1, busy_o stays 0, no writes.
REQ-041 s_tvalid toggled randomly during a load -> write sequence identical to the no-stall case.
REQ-042 abort_i at word 7 or reset_ni pulsed low at word 7 -> no writes after word 6's strobe, no done_o; the next load starts at addr 0.

Source files
------------

// File: rtl/mp_coeff_loader.sv
// Streams AXI-Stream coefficient words into one LUT, or into all M+1 LUTs back-to-back,
// producing a registered write strobe/address/select with error and completion reporting.
module mp_coeff_loader #(
  parameter int M           = 3,
  parameter int RESOLUTION  = 4096,
  parameter int COEFF_WIDTH = $clog2(RESOLUTION)
) (
  input  logic                   AXI_clk_i,
  input  logic                   reset_ni,
  input  logic                   start_i,
  input  logic                   all_i,
  input  logic [$clog2(M):0]     lut_sel_i,
  input  logic                   abort_i,
  input  logic [31:0]            s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic                   s_tlast,
  output logic [31:0]            coeff_data_o,
  output logic [COEFF_WIDTH-1:0] coeff_addr_o,
  output logic [$clog2(M):0]     coeff_num_o,
  output logic                   coeff_en_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam int NUM_W = $clog2(M) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [COEFF_WIDTH-1:0] LAST_ADDR = COEFF_WIDTH'(RESOLUTION - 1);
  localparam logic [NUM_W-1:0]       LAST_NUM  = NUM_W'(M);

  logic [1:0]             state_reg, state_next;
  logic [COEFF_WIDTH-1:0] addr_reg, addr_next;
  logic [NUM_W-1:0]       num_reg, num_next;
  logic                   all_mode_reg, all_mode_next;
  logic                   err_reg, err_next;
  logic                   handshake;
  logic                   at_end;

  // Abort withdraws ready immediately so the aborted cycle can never be accepted.
  assign s_tready  = (state_reg == LOAD) && !abort_i;
  assign handshake = s_tvalid && s_tready;
  assign at_end    = (addr_reg == LAST_ADDR);

  assign busy_o = (state_reg == LOAD);
  assign done_o = (state_reg == DONE);
  assign err_o  = err_reg;

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    num_next      = num_reg;
    all_mode_next = all_mode_reg;
    err_next      = err_reg;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          if (all_i || (lut_sel_i <= LAST_NUM)) begin
            num_next      = all_i ? '0 : lut_sel_i;
            addr_next     = '0;
            all_mode_next = all_i;
            err_next      = 1'b0;
            state_next    = LOAD;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      LOAD: begin
        if (abort_i) begin
          state_next = IDLE;
        end else if (handshake) begin
          if (at_end) begin
            // A missing tlast is flagged but the table is still taken as complete.
            if (!s_tlast) err_next = 1'b1;
            if (all_mode_reg && (num_reg < LAST_NUM)) begin
              num_next  = num_reg + 1'b1;
              addr_next = '0;
            end else begin
              state_next = DONE;
            end
          end else if (s_tlast) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end else begin
            addr_next = addr_reg + 1'b1;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge AXI_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      num_reg      <= '0;
      all_mode_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      num_reg      <= num_next;
      all_mode_reg <= all_mode_next;
      err_reg      <= err_next;
    end
  end

  // Write port is registered: a word accepted at one edge is written during the next cycle.
  always_ff @(posedge AXI_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      coeff_en_o   <= 1'b0;
      coeff_data_o <= '0;
      coeff_addr_o <= '0;
      coeff_num_o  <= '0;
    end else begin
      coeff_en_o <= handshake;
      if (handshake) begin
        coeff_data_o <= s_tdata;
        coeff_addr_o <= addr_reg;
        coeff_num_o  <= num_reg;
      end
    end
  end

endmodule
